// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multicycle RV32I core: opcode constants, the
// control FSM state enumeration, the mux-select encodings used by the
// datapath (immediate format, ALU operands, ALU op, result source) and the
// one-hot instruction class produced by opcode_class.
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_ALU_WB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_sel_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'd0,
        SRCA_OLDPC = 2'd1,
        SRCA_RS1   = 2'd2
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALUREG = 2'd0,
        RES_MEM    = 2'd1,
        RES_IMM    = 2'd2,
        RES_ALUOUT = 2'd3
    } result_sel_t;

    // Exactly one field is set for any opcode.
    typedef struct packed {
        logic illegal;
        logic lui;
        logic jal;
        logic branch;
        logic store;
        logic load;
        logic alu_i;
        logic alu_r;
    } op_class_t;

endpackage

// File: rtl/opcode_class.sv
// ---------------------------------------------------------------------------
// opcode_class
// Combinational map from the 7-bit RV32I opcode to a one-hot instruction
// class. Anything outside the supported subset is flagged illegal.
//   i_opcode  in  7  IR[6:0]
//   o_class   out 8  one-hot class (op_class_t)
// ---------------------------------------------------------------------------
module opcode_class
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_class_t  o_class
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OP_R:      o_class.alu_r   = 1'b1;
            OP_I:      o_class.alu_i   = 1'b1;
            OP_LOAD:   o_class.load    = 1'b1;
            OP_STORE:  o_class.store   = 1'b1;
            OP_BRANCH: o_class.branch  = 1'b1;
            OP_JAL:    o_class.jal     = 1'b1;
            OP_LUI:    o_class.lui     = 1'b1;
            default:   o_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multicycle RV32I core. Sequences fetch, decode,
// execute, memory and write-back over the shared datapath.
//   clk, rst        clock, synchronous active-high reset
//   opcode          IR[6:0], valid from DECODE onward
//   funct3_0        IR[12]: 0 = BEQ, 1 = BNE
//   zero            ALU zero flag
//   mem_ready       completion of the current memory request
//   pc_we, ir_we, reg_we            datapath write enables
//   mem_req, mem_we, adr_sel        memory port control
//   alu_src_a, alu_src_b, alu_op    ALU operand / operation selects
//   imm_sel, result_sel             immediate format, write-back source
//   trap            illegal opcode seen (held until reset)
// ---------------------------------------------------------------------------
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       funct3_0,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_sel,
    output logic [1:0] result_sel,
    output logic       trap
);

    state_t    r_state;
    state_t    w_next;
    op_class_t w_class;

    opcode_class u_opcode_class (
        .i_opcode (opcode),
        .o_class  (w_class)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if      (w_class.alu_r)                  w_next = S_EXEC_R;
                else if (w_class.alu_i)                  w_next = S_EXEC_I;
                else if (w_class.load || w_class.store)  w_next = S_MEM_ADR;
                else if (w_class.branch)                 w_next = S_BRANCH;
                else if (w_class.jal)                    w_next = S_JAL;
                else if (w_class.lui)                    w_next = S_LUI;
                else                                     w_next = S_TRAP;
            end
            S_EXEC_R:  w_next = S_ALU_WB;
            S_EXEC_I:  w_next = S_ALU_WB;
            S_MEM_ADR: w_next = w_class.store ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WB:  w_next = S_FETCH;
            S_MEM_WR:  if (mem_ready) w_next = S_FETCH;
            S_ALU_WB:  w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_JAL:     w_next = S_ALU_WB;
            S_LUI:     w_next = S_FETCH;
            S_TRAP:    w_next = S_TRAP;
            default:   w_next = S_FETCH;
        endcase
    end

    // Output decode. Everything is forced low while rst is high so that an
    // abandoned memory request never shows mem_req/mem_we during reset.
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_sel    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        imm_sel    = IMM_I;
        result_sel = RES_ALUREG;
        trap       = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_sel = RES_ALUOUT;
                    // PC+4 and IR load only once the instruction word arrives.
                    ir_we      = mem_ready;
                    pc_we      = mem_ready;
                end
                S_DECODE: begin
                    // Precompute PC-relative target; JAL needs the J-format offset.
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_sel   = w_class.jal ? IMM_J : IMM_B;
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALU_FUNCT;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_sel   = IMM_I;
                    alu_op    = ALU_FUNCT;
                end
                S_MEM_ADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_sel   = w_class.store ? IMM_S : IMM_I;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    adr_sel = 1'b1;
                end
                S_MEM_WB: begin
                    reg_we     = 1'b1;
                    result_sel = RES_MEM;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_sel = 1'b1;
                end
                S_ALU_WB: begin
                    reg_we     = 1'b1;
                    result_sel = RES_ALUREG;
                end
                S_BRANCH: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_op     = ALU_SUB;
                    result_sel = RES_ALUREG;
                    // BEQ takes on zero, BNE on not-zero.
                    pc_we      = zero ^ funct3_0;
                end
                S_JAL: begin
                    // PC <- target held from DECODE; ALU forms the link old PC + 4.
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    result_sel = RES_ALUREG;
                    pc_we      = 1'b1;
                end
                S_LUI: begin
                    imm_sel    = IMM_U;
                    result_sel = RES_IMM;
                    reg_we     = 1'b1;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
